uart_tx_controller: RTL

Sequences one UART transmit frame at a time. Accepts a byte over a valid/ready handshake, computes its parity, and assembles the 11-bit frame (start, 8 data LSB-first, parity, stop). It then serialises the frame onto the line at a programmable baud rate. It sits between the byte source (host logic or FIFO) and the `TxD` pin, and owns the transmitter's baud counter and bit sequencing.

---
 rtl/uart_pkg.sv | 12 +
 rtl/tx_frame_builder.sv | 11 +
 rtl/uart_tx_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state type and parity helper for the UART transmit path.
package uart_pkg;
   localparam int   FRAME_BITS = 11;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

   typedef enum logic {IDLE, SEND} tx_state_t;

   function automatic logic calc_parity(input logic [7:0] data, input logic odd);
      return odd ? ~^data : ^data;
   endfunction
endpackage

// File: rtl/tx_frame_builder.sv
// Combinational frame assembly: {stop, parity, data[7:0], start}, start bit at index 0.
module tx_frame_builder
   import uart_pkg::*;
#(
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic [7:0]            data_i,
   output logic [FRAME_BITS-1:0] frame_o
);
   assign frame_o = {STOP_BIT, calc_parity(data_i, PARITY_ODD), data_i, START_BIT};
endmodule

// File: rtl/uart_tx_controller.sv
// UART transmitter: accepts one byte per handshake and shifts an 11-bit frame onto TxD.
module uart_tx_controller
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV   = 5208,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       TxD,
   output logic       busy
);
   localparam int              CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

   tx_state_t             state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            bit_q, bit_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [FRAME_BITS-1:0] frame_w;
   logic                  txd_q, txd_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;
   logic                  busy_q;
   logic                  accept;
   logic                  baud_wrap;
   logic                  last_bit;

   tx_frame_builder #(.PARITY_ODD(PARITY_ODD)) u_frame (
      .data_i  (tx_data),
      .frame_o (frame_w)
   );

   assign accept    = tx_valid && ready_q;
   assign baud_wrap = (cnt_q == CNT_LAST);
   assign last_bit  = (bit_q == BIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         frame_q <= '1;
         txd_q   <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         txd_q   <= txd_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         busy_q  <= ~ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SEND;
         SEND:    if (baud_wrap && last_bit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The frame register shifts right on every bit boundary, so TxD always
   // takes bit 1 of the current frame and ones fill in behind the stop bit.
   always_comb begin
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      txd_d   = txd_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               frame_d = frame_w;
               txd_d   = frame_w[0];
               ready_d = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         SEND: begin
            if (baud_wrap) begin
               cnt_d = '0;
               if (last_bit) begin
                  bit_d   = '0;
                  frame_d = '1;
                  txd_d   = STOP_BIT;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  frame_d = {STOP_BIT, frame_q[FRAME_BITS-1:1]};
                  txd_d   = frame_q[1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            txd_d   = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   assign TxD      = txd_q;
   assign tx_ready = ready_q;
   assign tx_done  = done_q;
   assign busy     = busy_q;
endmodule
